// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int PS2_FILTER_DEF  = 8;
  localparam int PS2_TIMEOUT_DEF = 50000;
  localparam int PS2_FRAME_BITS  = 11;
  // start + parity + stop are the non-data bits of a frame
  localparam int PS2_DATA_BITS   = PS2_FRAME_BITS - 3;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// PS/2 pins plus the received-byte strobe bus seen by the keyboard latch.
interface ps2_receiver_if import ps2_pkg::*;;

  logic                     ps2_clk;
  logic                     ps2_dat;
  logic [PS2_DATA_BITS-1:0] ps2_data;
  logic                     ps2_hit;
  logic                     ps2_err;

  modport master (
    input  ps2_clk,
    input  ps2_dat,
    output ps2_data,
    output ps2_hit,
    output ps2_err
  );

  modport slave (
    output ps2_clk,
    output ps2_dat,
    input  ps2_data,
    input  ps2_hit,
    input  ps2_err
  );

endinterface

// File: rtl/ps2_filter.sv
// Synchronises both PS/2 pins and deglitches the clock; emits a one-cycle
// pulse when the filtered clock falls.
module ps2_filter import ps2_pkg::*; #(
  parameter int FILTER = PS2_FILTER_DEF
) (
  input  logic clock50,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic sdat,
  output logic fclk,
  output logic fall
);

  localparam int CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic             clk_meta_q, clk_meta_d;
  logic             clk_sync_q, clk_sync_d;
  logic             dat_meta_q, dat_meta_d;
  logic             dat_sync_q, dat_sync_d;
  logic             fclk_q, fclk_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count restarts whenever the synchronised clock agrees with fclk,
  // so only an uninterrupted run of FILTER differing samples moves fclk.
  always_comb begin
    clk_meta_d = ps2_clk;
    clk_sync_d = clk_meta_q;
    dat_meta_d = ps2_dat;
    dat_sync_d = dat_meta_q;
    fclk_d     = fclk_q;
    fall_d     = 1'b0;
    cnt_d      = '0;
    if (clk_sync_q != fclk_q) begin
      if (cnt_q == CNT_W'(FILTER - 1)) begin
        fclk_d = clk_sync_q;
        fall_d = fclk_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      fclk_q     <= 1'b1;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      fclk_q     <= fclk_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
    end
  end

  assign sdat = dat_sync_q;
  assign fclk = fclk_q;
  assign fall = fall_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 receiver: deserialises 11-bit frames into scan-code bytes with a
// one-cycle hit strobe per good byte and an error strobe for bad frames.
module ps2_receiver import ps2_pkg::*; #(
  parameter int FILTER  = PS2_FILTER_DEF,
  parameter int TIMEOUT = PS2_TIMEOUT_DEF
) (
  input  logic           clock50,
  input  logic           reset_n,
  ps2_receiver_if.master bus
);

  localparam int               BIT_W     = $clog2(PS2_DATA_BITS);
  localparam logic [16:0]      TMO_LIMIT = 17'(TIMEOUT);

  logic sdat;
  logic fclk;
  logic fall;

  ps2_filter #(.FILTER(FILTER)) u_filter (
    .clock50 (clock50),
    .reset_n (reset_n),
    .ps2_clk (bus.ps2_clk),
    .ps2_dat (bus.ps2_dat),
    .sdat    (sdat),
    .fclk    (fclk),
    .fall    (fall)
  );

  ps2_state_e               state_q, state_d;
  logic [PS2_DATA_BITS-1:0] sh_q, sh_d;
  logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic                     par_ok_q, par_ok_d;
  logic [16:0]              tmo_q, tmo_d;
  logic [PS2_DATA_BITS-1:0] data_q, data_d;
  logic                     hit_q, hit_d;
  logic                     err_q, err_d;
  logic                     timed_out;

  // An edge event on the expiry cycle takes priority over the timeout.
  assign timed_out = (state_q != ST_IDLE) && !fall && (tmo_q >= TMO_LIMIT);

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    par_ok_d  = par_ok_q;
    data_d    = data_q;
    hit_d     = 1'b0;
    err_d     = 1'b0;

    if (state_q == ST_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fall && !sdat) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fall) begin
          sh_d = {sdat, sh_q[PS2_DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_W'(PS2_DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_ok_d = odd_parity_ok(sh_q, sdat);
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (sdat && par_ok_q) begin
            data_d = sh_q;
            hit_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timed_out) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      par_ok_q  <= 1'b0;
      tmo_q     <= '0;
      data_q    <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      par_ok_q  <= par_ok_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
    end
  end

  assign bus.ps2_data = data_q;
  assign bus.ps2_hit  = hit_q;
  assign bus.ps2_err  = err_q;

endmodule
